// File: rtl/branch_resolver.sv
// Branch resolution and recovery unit.
// It shadows the IF/ID register with the fetched PC and its predicted next PC.
// In ID it checks the prediction and raises a same-cycle flush and redirect on a
// mismatch. It also sends a registered training packet to the predictor and keeps
// saturating branch and mispredict counters.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | normal operation, ID prediction is compared when valid
// RECOVER | cycle after a flush, ID holds a killed bubble, no compare
module branch_resolver #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             is_stall,
    input  logic [31:0]      IF_pc,
    input  logic [31:0]      IF_predicted_pc,
    input  logic             ID_branch,
    input  logic             ID_bcond,
    input  logic [31:0]      ID_next_pc,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target,
    output logic             upd_taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q;
    logic [31:0] pred_q;
    logic        valid_q;
    logic        res;
    logic        mis;

    // Resolve/mispredict decode plus next-state; stalls hide unfinished ID operands
    always_comb begin
        state_nxt   = state;
        res         = valid_q & ~is_stall & (state == IDLE);
        mis         = res & (ID_next_pc != pred_q);
        flush       = mis;
        redirect_pc = mis ? ID_next_pc : 32'h0;
        case (state)
            IDLE:    if (mis) state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // IF/ID shadow; the wrong-path fetch during a flush is captured as invalid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= 32'h0;
            pred_q  <= 32'h0;
            valid_q <= 1'b0;
        end else if (!is_stall) begin
            pc_q    <= IF_pc;
            pred_q  <= IF_predicted_pc;
            valid_q <= ~flush;
        end
    end

    // Training packet: one-cycle strobe, payload holds between strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_valid  <= 1'b0;
            upd_pc     <= 32'h0;
            upd_target <= 32'h0;
            upd_taken  <= 1'b0;
        end else if (res && ID_branch) begin
            upd_valid  <= 1'b1;
            upd_pc     <= pc_q;
            upd_target <= ID_next_pc;
            upd_taken  <= ID_bcond;
        end else begin
            upd_valid  <= 1'b0;
        end
    end

    // Saturating performance counters, they stick at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (res && ID_branch && (branch_count != {CNT_W{1'b1}}))
                branch_count <= branch_count + 1'b1;
            if (mis && (mispredict_count != {CNT_W{1'b1}}))
                mispredict_count <= mispredict_count + 1'b1;
        end
    end

endmodule
